// File: rtl/logic_unit_pkg.sv
// Shared encodings for the multi-cycle logic unit: opcode values and FSM states.
package logic_unit_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational CHUNK-wide bitwise operator; one chunk of the datapath per cycle.
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic [1:0]       op,
    output logic [CHUNK-1:0] y
);

    always_comb begin
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~(a | b);
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle AND/OR/XOR/NOR unit: one CHUNK per cycle, valid/ready in and out, zero flag.
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("logic_unit_seq: WIDTH must be a multiple of CHUNK");
    end

    state_e                       state_q;
    logic [NCHUNK-1:0][CHUNK-1:0] a_q, b_q, res_q;
    logic [1:0]                   op_q;
    logic [IDXW-1:0]              idx_q;
    logic                         zacc_q;
    logic [CHUNK-1:0]             a_sel, b_sel, y_chunk;
    logic                         accept;

    // Explicit compare-mux keeps the index width independent of NCHUNK.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_sel = a_q[i];
                b_sel = b_q[i];
            end
        end
    end

    logic_slice #(.CHUNK(CHUNK)) u_slice (
        .a  (a_sel),
        .b  (b_sel),
        .op (op_q),
        .y  (y_chunk)
    );

    assign in_ready  = !rst && ((state_q == ST_IDLE) || (state_q == ST_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign zero      = (state_q == ST_DONE) && zacc_q;
    assign result    = res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            idx_q   <= '0;
            res_q   <= '0;
            zacc_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // A DONE-state accept also retires the pending result (back-to-back).
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        idx_q   <= '0;
                        res_q   <= '0;
                        zacc_q  <= 1'b1;
                        state_q <= ST_BUSY;
                    end else if (state_q == ST_DONE && out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (idx_q == IDXW'(i)) res_q[i] <= y_chunk;
                    end
                    if (y_chunk != '0) zacc_q <= 1'b0;
                    if (idx_q == LAST) begin
                        idx_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: directed cases plus random ops against a whole-word reference.
module tb_logic_unit_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [31:0] a, b, result;
    logic [1:0]  op;

    logic        rst1, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_zero, c_busy;
    logic [31:0] c_a, c_b, c_result;
    logic [1:0]  c_op;

    int ntests = 0;
    int nfail  = 0;

    logic_unit_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    logic_unit_seq #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst(rst1), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .a(c_a), .b(c_b), .op(c_op), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .result(c_result), .zero(c_zero), .busy(c_busy)
    );

    function automatic logic [31:0] ref_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a transaction, then scrambles the inputs and waits for out_valid.
    task automatic txn(input logic [31:0] ta, input logic [31:0] tb_, input logic [1:0] top,
                       output int lat, output int bcnt);
        a = ta; b = tb_; op = top; in_valid = 1'b1;
        #1;
        chk("in_ready_at_accept", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 1; bcnt = 0;
        while (!out_valid && lat < 50) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
    endtask

    task automatic chk_done(input string tag, input logic [31:0] exp, input int lat, input int bcnt);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
        chk({tag, "_latency"}, 32'(lat), 32'd5);
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd4);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, h;
        logic [31:0] ta, tb_, exp;
        logic [1:0]  top;

        rst = 1; rst1 = 1; in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0;
        c_in_valid = 0; c_out_ready = 0; c_a = 0; c_b = 0; c_op = 0;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_in_ready32", 32'(c_in_ready), 32'd0);
        rst = 0; rst1 = 0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_in_ready32", 32'(c_in_ready), 32'd1);

        // AND, then three cycles of backpressure
        txn(32'hF0F0_1234, 32'hFF00_FF00, 2'b00, lat, bcnt);
        chk_done("and", 32'hF000_1200, lat, bcnt);
        chk("and_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", result, 32'hF000_1200);
            chk("bp_zero", 32'(zero), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        out_ready = 1'b0;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_zero", 32'(zero), 32'd0);

        // NOR giving zero, then back-to-back XOR from DONE
        txn(32'hFFFF_FFFF, 32'h0000_0000, 2'b11, lat, bcnt);
        chk_done("nor", 32'h0000_0000, lat, bcnt);
        out_ready = 1'b1;
        txn(32'h0000_00FF, 32'h0000_0F0F, 2'b10, lat, bcnt);
        chk_done("b2b_xor", 32'h0000_0FF0, lat, bcnt);
        consume();

        // Only the top chunk nonzero must still clear zero
        txn(32'hA500_0000, 32'h0000_0000, 2'b01, lat, bcnt);
        chk_done("top_chunk", 32'hA500_0000, lat, bcnt);
        consume();

        // Reset while idx == 2
        a = $urandom; b = $urandom; op = 2'($urandom); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_after_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        // Single-chunk instance
        c_a = 32'h0000_0001; c_b = 32'h8000_0000; c_op = 2'b01; c_in_valid = 1'b1;
        step();
        c_in_valid = 1'b0; c_a = $urandom; c_b = $urandom;
        lat = 1;
        while (!c_out_valid && lat < 20) begin step(); lat++; end
        chk("c32_latency", 32'(lat), 32'd2);
        chk("c32_result", c_result, 32'h8000_0001);
        chk("c32_zero", 32'(c_zero), 32'd0);
        c_out_ready = 1'b1;
        step();
        c_out_ready = 1'b0;
        chk("c32_consumed", 32'(c_out_valid), 32'd0);

        // Random ops with random backpressure and back-to-back issue
        for (int n = 0; n < 24; n++) begin
            ta  = $urandom;
            tb_ = (n % 6 == 0) ? ta : $urandom;
            top = 2'($urandom);
            exp = ref_op(ta, tb_, top);
            txn(ta, tb_, top, lat, bcnt);
            chk_done("rand", exp, lat, bcnt);
            h = $urandom_range(0, 2);
            for (int k = 0; k < h; k++) begin
                step();
                chk("rand_hold_result", result, exp);
                chk("rand_hold_valid", 32'(out_valid), 32'd1);
            end
            if ($urandom_range(0, 1) == 1) out_ready = 1'b1;
            else consume();
        end
        consume();
        chk("final_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Parametrised, multi-cycle bitwise logic unit for the CPU datapath. It generalises the fixed 32-bit AND gate array to four MIPS logic ops (AND, OR, XOR, NOR) at any `WIDTH`. Operands are processed `CHUNK` bits per cycle under a valid/ready handshake, and the unit produces a zero flag. It sits beside the ALU and serves logic-class instructions, trading latency for slice area.

## Interface

Parameters:

- `WIDTH`, default 32: operand and result width in bits.
- `CHUNK`, default 8: bits processed per cycle. `WIDTH % CHUNK == 0` is required, and elaboration fails otherwise. `NCHUNK = WIDTH/CHUNK`.

Ports:

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operand/op presented.
- `in_ready` output 1: unit can accept a new transaction.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `op` input 2: 00 AND, 01 OR, 10 XOR, 11 NOR.
- `out_valid` output 1: `result`/`zero` valid.
- `out_ready` input 1: consumer accepts result.
- `result` output WIDTH: op(a, b).
- `zero` output 1: `result == 0`.
- `busy` output 1: high in BUSY state.

## Operation

- States are IDLE, BUSY and DONE.
- **Accept:** when `in_valid && in_ready`, latch `a`, `b` and `op`, set `idx=0`, clear the result register, set `zero_acc=1`, then go to BUSY.
- **BUSY:** each cycle, compute chunk `idx` (bits `idx*CHUNK +: CHUNK`) with the latched op and write it into `result[idx]`. Clear `zero_acc` if the chunk is nonzero, then increment `idx`.
  - When `idx == NCHUNK-1` completes, go to DONE.
- **DONE:** `out_valid=1`. `result` and `zero` are held stable until `out_valid && out_ready`.
  - Handshake completes with no new input: go to IDLE.
- **`in_ready`:** 1 in IDLE, and 1 in DONE while `out_ready` is 1. It is 0 in BUSY and 0 while `rst` is high.
- **Simultaneous handshakes in DONE:** when the output and input handshakes happen in the same cycle, both complete. The new operands are latched and the state goes directly to BUSY, giving back-to-back throughput.
- `in_valid` in BUSY is ignored; the upstream holds it.
- `out_ready` outside DONE has no effect.
- Inputs are sampled only at the accept edge. Changes to `a`, `b` or `op` afterwards do not affect the transaction in flight.

## Timing

- **Reset values:** state IDLE, `idx=0`, `result=0`, `zero=0`, `out_valid=0`, `busy=0`. `in_ready` is 0 during the reset cycle and 1 from the first cycle after.
- **Reset mid-operation:** when `rst` is asserted in BUSY or DONE, the transaction is dropped. The next cycle shows the reset values, and no `out_valid` is ever emitted for the dropped transaction.
- **Latency:** an accept at edge k gives `out_valid` high in the cycle after edge k+NCHUNK, which is NCHUNK+1 cycles.
  - Default parameters: 5 cycles.
  - `CHUNK == WIDTH`: 2 cycles.
- **Throughput:** one result per NCHUNK+1 cycles with back-to-back handshakes. `result` changes only at an accept (cleared) or during BUSY.
- **`zero` qualification:** `zero` is meaningful only while `out_valid` is 1. Outside DONE it reads 0.
- **Wrap-around:** `idx` is `$clog2(NCHUNK)` bits, minimum 1. It never wraps within a transaction; the transition to DONE occurs at `NCHUNK-1`.

## Structure

- Package `logic_unit_pkg`:
  - `op` encoding constants: `OP_AND`, `OP_OR`, `OP_XOR`, `OP_NOR`.
  - state encoding: IDLE, BUSY, DONE.
- Sub-module `logic_slice` (parameter `CHUNK`): combinational CHUNK-wide op selector with inputs `a`, `b`, `op` and output `y`. The top module instantiates one slice and muxes the chunk in by `idx`.

## Test plan

- **AND, default parameters:** `a=0xF0F0_1234`, `b=0xFF00_FF00`, `op=00` → `result=0xF000_1200`, `zero=0`, `out_valid` rises 5 cycles after accept, `busy` is high for exactly 4 cycles.
- **NOR:** `a=0xFFFF_FFFF`, `b=0x0000_0000`, `op=11` → `result=0x0000_0000`, `zero=1`.
- **Backpressure:** hold `out_ready=0` for 3 cycles in DONE → `result` and `zero` stay constant and `in_ready=0`. Raise `out_ready` → handshake completes, state returns to IDLE, `in_ready=1`.
- **Back-to-back:** in DONE, drive `out_ready=1` and `in_valid=1` with XOR, `a=0x0000_00FF`, `b=0x0000_0F0F` → first result is consumed the same cycle. The second result is `0x0000_0FF0`, `zero=0`, arriving 5 cycles later, with no IDLE cycle in between.
- **Reset mid-BUSY:** assert `rst` when `idx==2` → next cycle `out_valid=0`, `result=0`, `busy=0`. `in_ready=1` the cycle after reset deasserts, and no stale result ever appears.
- **`CHUNK=32` instance:** OR, `a=0x0000_0001`, `b=0x8000_0000` → `result=0x8000_0001`, 2-cycle latency.
